booth_mult_seq: RTL and testbench

- Parametrised sequential radix-2 Booth multiplier with its controller and datapath in one block.
- Takes two WIDTH-bit operands through a valid/ready handshake and produces a 2*WIDTH-bit product.
- Signed or unsigned operation is selected per operation.
- Sits between the operand-entry/sequencing logic and the result display/consumer path; it replaces the fixed 8-bit, start-pulse driven multiplier control.

---
 rtl/booth_mult_seq.sv | 149 ++++++++++++++
 tb/tb_booth_mult_seq.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation.
// Valid/ready operand intake, one Booth step per clock, held result.
module booth_mult_seq #(
  parameter  int WIDTH = 8,
  localparam int ITER  = WIDTH + 1,
  localparam int CW    = $clog2(WIDTH + 2)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               op_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int EW = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [EW:0]        a_q, a_d;
  logic [EW-1:0]      q_q, q_d;
  logic               q1_q, q1_d;
  logic [EW-1:0]      m_q, m_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [EW:0]   m_ext;
  logic [EW:0]   sum;
  logic [EW:0]   a_sh;
  logic [EW-1:0] q_sh;
  logic          q1_sh;
  logic          accept;
  logic          last;
  logic [EW-1:0] mcand_ext;
  logic [EW-1:0] mplier_ext;

  assign accept = (state_q == IDLE) && in_valid;
  assign last   = (state_q == RUN) && (cnt_q == CW'(1));

  // Extra top bit makes unsigned operands look like positive signed ones.
  assign mcand_ext  = {op_signed & multiplicand[WIDTH-1], multiplicand};
  assign mplier_ext = {op_signed & multiplier[WIDTH-1], multiplier};

  // One Booth step: conditional add/sub, then arithmetic shift.
  always_comb begin
    m_ext = {m_q[EW-1], m_q};
    sum   = a_q;
    unique case ({q_q[0], q1_q})
      2'b01:   sum = a_q + m_ext;
      2'b10:   sum = a_q - m_ext;
      default: sum = a_q;
    endcase
    a_sh  = {sum[EW], sum[EW:1]};
    q_sh  = {sum[0], q_q[EW-1:1]};
    q1_sh = q_q[0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: in_ready = 1'b1;
      RUN:  busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Datapath next-state
  always_comb begin
    a_d    = a_q;
    q_d    = q_q;
    q1_d   = q1_q;
    m_d    = m_q;
    cnt_d  = cnt_q;
    prod_d = prod_q;
    if (accept) begin
      a_d   = '0;
      q_d   = mplier_ext;
      m_d   = mcand_ext;
      q1_d  = 1'b0;
      cnt_d = CW'(ITER);
    end else if (state_q == RUN) begin
      a_d   = a_sh;
      q_d   = q_sh;
      q1_d  = q1_sh;
      cnt_d = cnt_q - CW'(1);
      if (last) begin
        prod_d = {a_sh[WIDTH-2:0], q_sh};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      q_q    <= '0;
      q1_q   <= 1'b0;
      m_q    <= '0;
      cnt_q  <= '0;
      prod_q <= '0;
    end else begin
      a_q    <= a_d;
      q_q    <= q_d;
      q1_q   <= q1_d;
      m_q    <= m_d;
      cnt_q  <= cnt_d;
      prod_q <= prod_d;
    end
  end

  assign product = prod_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and swept checks for booth_mult_seq at WIDTH=8 and WIDTH=16.
// Expected products are hand-computed or from an integer reference.
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op_signed = 1'b0;
  logic [7:0]  mcand = '0;
  logic [7:0]  mplier = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] product;
  logic        busy;

  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic        w_op_signed = 1'b0;
  logic [15:0] w_mcand = '0;
  logic [15:0] w_mplier = '0;
  logic        w_out_valid;
  logic        w_out_ready = 1'b0;
  logic [31:0] w_product;
  logic        w_busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(8)) u_dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op_signed    (op_signed),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy)
  );

  booth_mult_seq #(.WIDTH(16)) u_dut16 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (w_in_valid),
    .in_ready     (w_in_ready),
    .op_signed    (w_op_signed),
    .multiplicand (w_mcand),
    .multiplier   (w_mplier),
    .out_valid    (w_out_valid),
    .out_ready    (w_out_ready),
    .product      (w_product),
    .busy         (w_busy)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] ref8(input logic s,
                                       input logic [7:0] m,
                                       input logic [7:0] q);
    int a;
    int b;
    a = s ? {{24{m[7]}}, m} : {24'b0, m};
    b = s ? {{24{q[7]}}, q} : {24'b0, q};
    return 16'(a * b);
  endfunction

  // Accept one operand pair, wait for out_valid, optionally consume.
  task automatic run8(input logic s, input logic [7:0] m,
                      input logic [7:0] q, input bit consume,
                      output int lat, output logic [15:0] p);
    op_signed = s;
    mcand     = m;
    mplier    = q;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    op_signed = ~s;
    mcand     = ~m;
    mplier    = ~q;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    p = product;
    if (consume) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      $display("FAIL reset_flags: got %b want 100",
               {in_ready, out_valid, busy});
      n_bad++;
    end
    n_cmp++;
    if (product !== 16'h0000) begin
      $display("FAIL reset_product: got %h want 0000", product);
      n_bad++;
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      $display("FAIL idle_after_reset: got %b want 100",
               {in_ready, out_valid, busy});
      n_bad++;
    end
  endtask

  task automatic test_signed_basic;
    int lat;
    logic [15:0] p;
    run8(1'b1, 8'hFD, 8'h05, 1'b1, lat, p);
    n_cmp++;
    if (lat !== 9) begin
      $display("FAIL latency_m3x5: got %0d want 9", lat);
      n_bad++;
    end
    n_cmp++;
    if (p !== 16'hFFF1) begin
      $display("FAIL prod_m3x5: got %h want fff1", p);
      n_bad++;
    end
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      $display("FAIL idle_after_consume: got %b want 100",
               {in_ready, out_valid, busy});
      n_bad++;
    end
  endtask

  task automatic test_full_range;
    int lat;
    logic [15:0] p;
    run8(1'b0, 8'hFF, 8'hFF, 1'b1, lat, p);
    n_cmp++;
    if (p !== 16'hFE01) begin
      $display("FAIL prod_u255x255: got %h want fe01", p);
      n_bad++;
    end
    run8(1'b1, 8'hFF, 8'hFF, 1'b1, lat, p);
    n_cmp++;
    if (p !== 16'h0001) begin
      $display("FAIL prod_sm1xm1: got %h want 0001", p);
      n_bad++;
    end
  endtask

  task automatic test_signed_corners;
    int lat;
    logic [15:0] p;
    run8(1'b1, 8'h80, 8'h80, 1'b1, lat, p);
    n_cmp++;
    if (p !== 16'h4000) begin
      $display("FAIL prod_m128xm128: got %h want 4000", p);
      n_bad++;
    end
    run8(1'b1, 8'h80, 8'h7F, 1'b1, lat, p);
    n_cmp++;
    if (p !== 16'hC080) begin
      $display("FAIL prod_m128x127: got %h want c080", p);
      n_bad++;
    end
    run8(1'b1, 8'h00, 8'hFF, 1'b1, lat, p);
    n_cmp++;
    if (p !== 16'h0000) begin
      $display("FAIL prod_0xm1: got %h want 0000", p);
      n_bad++;
    end
  endtask

  task automatic test_backpressure;
    int lat;
    logic [15:0] p;
    run8(1'b0, 8'd12, 8'd11, 1'b0, lat, p);
    n_cmp++;
    if (p !== 16'h0084) begin
      $display("FAIL prod_12x11: got %h want 0084", p);
      n_bad++;
    end
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        in_valid  = 1'b1;
        op_signed = 1'b1;
        mcand     = 8'h55;
        mplier    = 8'hAA;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_cmp++;
      if ({product, in_ready, out_valid} !== {16'h0084, 2'b01}) begin
        $display("FAIL hold_cycle%0d: got %h/%b%b want 0084/01",
                 i, product, in_ready, out_valid);
        n_bad++;
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      $display("FAIL release_idle: got %b want 100",
               {in_ready, out_valid, busy});
      n_bad++;
    end
    n_cmp++;
    if (product !== 16'h0084) begin
      $display("FAIL product_kept_idle: got %h want 0084", product);
      n_bad++;
    end
    run8(1'b0, 8'd3, 8'd4, 1'b1, lat, p);
    n_cmp++;
    if (p !== 16'h000C || lat !== 9) begin
      $display("FAIL after_release_3x4: got %h/%0d want 000c/9", p, lat);
      n_bad++;
    end
  endtask

  task automatic test_reset_midop;
    int lat;
    logic [15:0] p;
    bit seen;
    op_signed = 1'b0;
    mcand     = 8'd200;
    mplier    = 8'd100;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      $display("FAIL midop_reset_flags: got %b want 100",
               {in_ready, out_valid, busy});
      n_bad++;
    end
    n_cmp++;
    if (product !== 16'h0000) begin
      $display("FAIL midop_reset_product: got %h want 0000", product);
      n_bad++;
    end
    #2;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      $display("FAIL no_partial_result: got %b want 0", seen);
      n_bad++;
    end
    run8(1'b0, 8'd7, 8'd6, 1'b1, lat, p);
    n_cmp++;
    if (p !== 16'h002A || lat !== 9) begin
      $display("FAIL after_reset_7x6: got %h/%0d want 002a/9", p, lat);
      n_bad++;
    end
  endtask

  task automatic test_width16;
    int lat;
    logic [31:0] p;
    w_op_signed = 1'b1;
    w_mcand     = 16'h8000;
    w_mplier    = 16'h0003;
    w_in_valid  = 1'b1;
    @(posedge clk);
    #1;
    w_in_valid = 1'b0;
    w_mcand    = 16'h1234;
    lat = 0;
    while (!w_out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    p = w_product;
    w_out_ready = 1'b1;
    @(posedge clk);
    #1;
    w_out_ready = 1'b0;
    n_cmp++;
    if (lat !== 17) begin
      $display("FAIL w16_latency: got %0d want 17", lat);
      n_bad++;
    end
    n_cmp++;
    if (p !== 32'hFFFE8000) begin
      $display("FAIL w16_m32768x3: got %h want fffe8000", p);
      n_bad++;
    end
    w_op_signed = 1'b0;
    w_mcand     = 16'hFFFF;
    w_mplier    = 16'hFFFF;
    w_in_valid  = 1'b1;
    @(posedge clk);
    #1;
    w_in_valid = 1'b0;
    lat = 0;
    while (!w_out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    p = w_product;
    w_out_ready = 1'b1;
    @(posedge clk);
    #1;
    w_out_ready = 1'b0;
    n_cmp++;
    if (p !== 32'hFFFE0001) begin
      $display("FAIL w16_u65535sq: got %h want fffe0001", p);
      n_bad++;
    end
  endtask

  task automatic test_sweep;
    int lat;
    logic [15:0] p;
    logic [15:0] exp;
    logic s;
    logic [7:0] m;
    logic [7:0] q;
    for (int i = 0; i < 1000; i++) begin
      s = 1'($urandom_range(0, 1));
      m = 8'($urandom);
      q = 8'($urandom);
      exp = ref8(s, m, q);
      run8(s, m, q, 1'b1, lat, p);
      n_cmp++;
      if (p !== exp || lat !== 9) begin
        $display("FAIL sweep%0d s=%b %h*%h: got %h/%0d want %h/9",
                 i, s, m, q, p, lat, exp);
        n_bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_signed_basic();
    test_full_range();
    test_signed_corners();
    test_backpressure();
    test_reset_midop();
    test_width16();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
